ram_wait_ctrl: RTL and testbench

//  Memory-side controller directly downstream of the direct-mapped cache. Services its
//  one-word-per-handshake refill and write-back traffic. Owns a single-port word array.

---
 rtl/ram_wait_ctrl_if.sv | 18 +
 rtl/ram_wait_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_wait_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wait_ctrl_if.sv
// Word handshake between the direct-mapped cache (master) and ram_wait_ctrl (slave).
interface ram_wait_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BUS_W  = 20
);
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [BUS_W-1:0]  mem_wdata;
  logic [BUS_W-1:0]  mem_rdata;
  logic              mem_ready;
  logic              mem_busy;

  modport master (output mem_req, mem_rw, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready, mem_busy);
  modport slave  (input  mem_req, mem_rw, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready, mem_busy);
endinterface

// File: rtl/ram_wait_ctrl.sv
// Main-memory model behind the cache: single-port word array, LATENCY wait states, one-cycle ready.
// Optional RAM_WAIT_CTRL_STATS_EN adds saturating rd_count/wr_count access counters.
module ram_wait_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WORD_W    = 10,
  parameter int unsigned BUS_W     = 20,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst,
  ram_wait_ctrl_if.slave mem_if
`ifdef RAM_WAIT_CTRL_STATS_EN
  ,
  output logic [15:0]    rd_count,
  output logic [15:0]    wr_count
`endif
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               enter_resp;
  logic [WORD_W-1:0]  mem_q [DEPTH];

  // Power-up image; the array is deliberately outside the reset domain.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_q[i] = '0;
  end

  if (BUS_W > WORD_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^mem_if.mem_wdata[BUS_W-1:WORD_W];
  end

  // Next state; *_d of the latched fields always names the access in flight.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.mem_req) begin
          addr_d  = mem_if.mem_addr;
          rw_d    = mem_if.mem_rw;
          wdata_d = mem_if.mem_wdata[WORD_W-1:0];
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    if (enter_resp && !rw_d) rdata_d = BUS_W'(mem_q[addr_d]);
    ready_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Write commit on RESP entry; a coinciding reset cancels it.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && rw_d) mem_q[addr_d] <= wdata_d;
  end

  assign mem_if.mem_rdata = rdata_q;
  assign mem_if.mem_ready = ready_q;
  assign mem_if.mem_busy  = busy_q;

`ifdef RAM_WAIT_CTRL_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (enter_resp) begin
      if (rw_d && (wr_cnt_q != 16'hFFFF))       wr_cnt_q <= wr_cnt_q + 16'd1;
      else if (!rw_d && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Randomized check of ram_wait_ctrl (LATENCY=2 and LATENCY=0 instances) against a word-array model.
module tb_ram_wait_ctrl;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WORD_W = 10;
  localparam int unsigned BUS_W  = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              req, rw;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  int                sel;

  ram_wait_ctrl_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus0 ();
  ram_wait_ctrl_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus1 ();

  assign bus0.mem_req   = req && (sel == 0);
  assign bus0.mem_rw    = rw;
  assign bus0.mem_addr  = addr;
  assign bus0.mem_wdata = wdata;
  assign bus1.mem_req   = req && (sel == 1);
  assign bus1.mem_rw    = rw;
  assign bus1.mem_addr  = addr;
  assign bus1.mem_wdata = wdata;

`ifdef RAM_WAIT_CTRL_STATS_EN
  logic [15:0] rd0, wr0, rd1, wr1;
`endif

  ram_wait_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BUS_W(BUS_W), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .mem_if(bus0)
`ifdef RAM_WAIT_CTRL_STATS_EN
    , .rd_count(rd0), .wr_count(wr0)
`endif
  );

  ram_wait_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BUS_W(BUS_W), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .mem_if(bus1)
`ifdef RAM_WAIT_CTRL_STATS_EN
    , .rd_count(rd1), .wr_count(wr1)
`endif
  );

  logic             ready_o, busy_o;
  logic [BUS_W-1:0] rdata_o;
  assign ready_o = (sel == 1) ? bus1.mem_ready : bus0.mem_ready;
  assign busy_o  = (sel == 1) ? bus1.mem_busy  : bus0.mem_busy;
  assign rdata_o = (sel == 1) ? bus1.mem_rdata : bus0.mem_rdata;

  // Reference model: per-instance word array, last read word, access counts.
  logic [WORD_W-1:0] mem_m [2][2**ADDR_W];
  logic [BUS_W-1:0]  rdata_m [2];
  int                lat [2];
  int unsigned       rd_m [2];
  int unsigned       wr_m [2];
  int unsigned       resp_cyc;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
  endfunction

  // One access on instance `sel`; entered and left at a negedge with the DUT idle.
  task automatic access(input logic a_rw, input logic [ADDR_W-1:0] a_addr,
                        input logic [WORD_W-1:0] a_data, input bit drop, input bit hold);
    int l;
    l     = lat[sel];
    req   = 1'b1;
    rw    = a_rw;
    addr  = a_addr;
    wdata = {(BUS_W-WORD_W)'($urandom), a_data};
    @(posedge clk);
    for (int k = 1; k <= l + 1; k++) begin
      @(negedge clk);
      check_eq("busy", 32'(busy_o), 32'd1);
      check_eq("ready", 32'(ready_o), 32'(k == l + 1));
      if (k == 1 && drop) begin
        req   = 1'b0;
        rw    = 1'($urandom);
        addr  = ADDR_W'($urandom);
        wdata = BUS_W'($urandom);
      end
    end
    resp_cyc = cyc;
    if (a_rw) begin
      mem_m[sel][a_addr] = a_data;
      wr_m[sel] = sat_inc(wr_m[sel]);
    end else begin
      rdata_m[sel] = BUS_W'(mem_m[sel][a_addr]);
      rd_m[sel] = sat_inc(rd_m[sel]);
    end
    check_eq("rdata", 32'(rdata_o), 32'(rdata_m[sel]));
    if (!hold) req = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy_o), 32'd0);
    check_eq("idle_ready", 32'(ready_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rdata_m[s] = '0;
      rd_m[s]    = 0;
      wr_m[s]    = 0;
    end
    check_eq("rst_ready0", 32'(bus0.mem_ready), 32'd0);
    check_eq("rst_busy0", 32'(bus0.mem_busy), 32'd0);
    check_eq("rst_rdata0", 32'(bus0.mem_rdata), 32'd0);
    check_eq("rst_ready1", 32'(bus1.mem_ready), 32'd0);
    check_eq("rst_busy1", 32'(bus1.mem_busy), 32'd0);
    check_eq("rst_rdata1", 32'(bus1.mem_rdata), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c1;
    bit          dr, hd;
    int          n;
    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 0; rst = 1'b1;
    lat[0] = 2; lat[1] = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2**ADDR_W; i++) mem_m[s][i] = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic write then read at LATENCY=2.
    access(1'b1, 10'h032, 10'h12C, 1'b0, 1'b0);
    access(1'b0, 10'h032, 10'h000, 1'b0, 1'b0);
    check_eq("t1_rdata", 32'(rdata_o), 32'h0012C);

    // Back-to-back reads with mem_req held high.
    access(1'b1, 10'h064, 10'h0A5, 1'b0, 1'b0);
    access(1'b1, 10'h065, 10'h35A, 1'b0, 1'b0);
    access(1'b0, 10'h064, 10'h000, 1'b0, 1'b1);
    c1 = resp_cyc;
    check_eq("t2_rdata_a", 32'(rdata_o), 32'h000A5);
    access(1'b0, 10'h065, 10'h000, 1'b0, 1'b0);
    check_eq("t2_rdata_b", 32'(rdata_o), 32'h0035A);
    check_eq("t2_period", resp_cyc - c1, 32'(lat[0] + 2));

    // Inputs dropped/changed during BUSY do not abort or redirect the write.
    access(1'b1, 10'h046, 10'h309, 1'b1, 1'b0);
    access(1'b0, 10'h046, 10'h000, 1'b0, 1'b0);
    check_eq("t3_rdata", 32'(rdata_o), 32'h00309);

    // Reset in the second BUSY cycle cancels the write and the pulse.
    req = 1'b1; rw = 1'b1; addr = 10'h046; wdata = 20'h001FF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rdata_m[s] = '0; rd_m[s] = 0; wr_m[s] = 0;
    end
    check_eq("t4_ready", 32'(ready_o), 32'd0);
    check_eq("t4_busy", 32'(busy_o), 32'd0);
    check_eq("t4_rdata", 32'(rdata_o), 32'd0);
    @(negedge clk);
    check_eq("t4_ready_late", 32'(ready_o), 32'd0);
    access(1'b0, 10'h046, 10'h000, 1'b0, 1'b0);
    check_eq("t4_readback", 32'(rdata_o), 32'h00309);

    // LATENCY=0 instance: read then write that must not touch rdata.
    sel = 1;
    access(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
    check_eq("t5_rdata", 32'(rdata_o), 32'd0);
    access(1'b1, 10'h005, 10'h2AA, 1'b0, 1'b0);
    check_eq("t5_rdata_kept", 32'(rdata_o), 32'd0);
    access(1'b0, 10'h005, 10'h000, 1'b0, 1'b0);
    check_eq("t5_readback", 32'(rdata_o), 32'h002AA);

    // Random traffic on both instances, clustered addresses for read-after-write.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      n   = 60;
      for (int i = 0; i < n; i++) begin
        dr = ($urandom_range(3) == 0);
        hd = !dr && (i != n - 1) && ($urandom_range(3) == 0);
        access(1'($urandom), ADDR_W'(10'h040 + 10'($urandom_range(15))),
               WORD_W'($urandom), dr, hd);
      end
    end

`ifdef RAM_WAIT_CTRL_STATS_EN
    sel = 0;
    do_reset();
    for (int i = 0; i < 3; i++) access(1'b1, ADDR_W'(i), WORD_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) access(1'b0, ADDR_W'(i), 10'h000, 1'b0, 1'b0);
    check_eq("st_wr", 32'(wr0), wr_m[0]);
    check_eq("st_rd", 32'(rd0), rd_m[0]);
    check_eq("st_wr_const", 32'(wr0), 32'd3);
    check_eq("st_rd_const", 32'(rd0), 32'd2);
    do_reset();
    check_eq("st_wr_rst", 32'(wr0), 32'd0);
    check_eq("st_rd_rst", 32'(rd0), 32'd0);
    force dut0.wr_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut0.wr_cnt_q;
    wr_m[0] = 32'hFFFE;
    for (int i = 0; i < 3; i++) access(1'b1, ADDR_W'(i), WORD_W'($urandom), 1'b0, 1'b0);
    check_eq("st_wr_sat", 32'(wr0), wr_m[0]);
    check_eq("st_wr_sat_const", 32'(wr0), 32'hFFFF);
    check_eq("st_rd_after", 32'(rd0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
